debug_cmd_parser: RTL and testbench

Byte-stream command front end for the debug path. Accepts command bytes over a valid/ready input channel and decodes them into select, read and write operations. Drives the `sel`/`addr`/`we`/`wdata` inputs of `debug_mux` and returns `debug_mux.rdata` as response bytes over a valid/ready output channel. Sits between the external debug transport (UART/SPI/logic-analyzer byte adapter) and `debug_mux`.

---
 rtl/debug_cmd_parser_pkg.sv | 29 ++
 rtl/debug_cmd_tx.sv | 45 ++++
 rtl/debug_cmd_parser.sv | 168 ++++++++++++++++
 tb/tb_debug_cmd_parser.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/debug_cmd_parser_pkg.sv
// Shared opcodes, FSM state encoding and response bytes for debug_cmd_parser.
// ST_ACK exists only when DEBUG_CMD_ACK_EN is defined.
package debug_cmd_pkg;

  localparam logic [1:0] OP_SELECT = 2'b00;
  localparam logic [1:0] OP_READ   = 2'b01;
  localparam logic [1:0] OP_WRITE  = 2'b10;
  localparam logic [1:0] OP_ECHO   = 2'b11;

  localparam logic [7:0] RESP_ECHO = 8'hA5;
  localparam logic [7:0] RESP_ACK  = 8'h5A;
  localparam logic [7:0] RESP_ERR  = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_WSTROBE,
    ST_RSAMPLE,
    ST_RSEND
`ifdef DEBUG_CMD_ACK_EN
    , ST_ACK
`endif
  } state_t;

  function automatic logic [7:0] ack_byte(input logic ok);
    return ok ? RESP_ACK : RESP_ERR;
  endfunction

endpackage

// File: rtl/debug_cmd_tx.sv
// Response transmitter: shifts out a loaded word LSB byte first over a
// valid/ready channel; done pulses with the final byte transfer.
module debug_cmd_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int BYTES      = DATA_WIDTH / 8,
  parameter int CW         = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_word,
  input  logic [CW:0]           load_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  done
);

  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cnt;

  assign out_data = shreg[7:0];
  assign done     = out_valid && out_ready && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      shreg     <= load_word;
      cnt       <= CW'(load_len - 1'b1);
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      // Final byte stays on out_data after valid drops.
      if (cnt == '0) begin
        out_valid <= 1'b0;
      end else begin
        shreg <= shreg >> 8;
        cnt   <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/debug_cmd_parser.sv
// Byte-stream command decoder driving debug_mux select/read/write.
// Define DEBUG_CMD_ACK_EN to acknowledge SELECT and WRITE with a response byte.
module debug_cmd_parser
  import debug_cmd_pkg::*;
#(
  parameter int CORES      = 4,
  parameter int LOG_CORES  = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic [LOG_CORES-1:0]  sel,
  output logic [4:0]            addr,
  output logic                  we,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  state_t                state;
  logic [CW-1:0]         wcnt;
  logic                  in_fire;
  logic                  sel_ok;
  logic [1:0]            op;
  logic                  tx_load;
  logic [DATA_WIDTH-1:0] tx_word;
  logic [CW:0]           tx_len;
  logic                  tx_done;

  assign in_fire = in_valid && in_ready;
  assign op      = in_data[7:6];
  assign sel_ok  = 32'(in_data[5:0]) < CORES;

  always_comb begin
    tx_load = 1'b0;
    tx_word = '0;
    tx_len  = (CW+1)'(1);
    case (state)
      ST_IDLE: begin
        if (in_fire && op == OP_ECHO) begin
          tx_load = 1'b1;
          tx_word = DATA_WIDTH'(RESP_ECHO);
        end
`ifdef DEBUG_CMD_ACK_EN
        if (in_fire && op == OP_SELECT) begin
          tx_load = 1'b1;
          tx_word = DATA_WIDTH'(ack_byte(sel_ok));
        end
`endif
      end
`ifdef DEBUG_CMD_ACK_EN
      ST_WSTROBE: begin
        tx_load = 1'b1;
        tx_word = DATA_WIDTH'(RESP_ACK);
      end
`endif
      ST_RSAMPLE: begin
        tx_load = 1'b1;
        tx_word = rdata;
        tx_len  = (CW+1)'(BYTES);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wcnt     <= '0;
      sel      <= '0;
      addr     <= '0;
      we       <= 1'b0;
      wdata    <= '0;
      in_ready <= 1'b0;
    end else begin
      we <= 1'b0;
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            case (op)
              OP_SELECT: begin
                if (sel_ok) sel <= in_data[LOG_CORES-1:0];
`ifdef DEBUG_CMD_ACK_EN
                state    <= ST_ACK;
                in_ready <= 1'b0;
`endif
              end
              OP_READ: begin
                addr     <= in_data[4:0];
                state    <= ST_RSAMPLE;
                in_ready <= 1'b0;
              end
              OP_WRITE: begin
                addr  <= in_data[4:0];
                wcnt  <= '0;
                state <= ST_WDATA;
              end
              default: begin
                state    <= ST_RSEND;
                in_ready <= 1'b0;
              end
            endcase
          end
        end
        ST_WDATA: begin
          if (in_fire) begin
            wdata[{wcnt, 3'b000} +: 8] <= in_data;
            if (wcnt == CW'(BYTES - 1)) begin
              we       <= 1'b1;
              state    <= ST_WSTROBE;
              in_ready <= 1'b0;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        ST_WSTROBE: begin
`ifdef DEBUG_CMD_ACK_EN
          state <= ST_ACK;
`else
          state    <= ST_IDLE;
          in_ready <= 1'b1;
`endif
        end
        ST_RSAMPLE: state <= ST_RSEND;
`ifdef DEBUG_CMD_ACK_EN
        ST_ACK,
`endif
        ST_RSEND: begin
          if (tx_done) begin
            state    <= ST_IDLE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  debug_cmd_tx #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTES      (BYTES),
    .CW         (CW)
  ) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tx_load),
    .load_word (tx_word),
    .load_len  (tx_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .done      (tx_done)
  );

endmodule

// File: tb/tb_debug_cmd_parser.sv
// Directed bench for debug_cmd_parser (CORES=4, DATA_WIDTH=8); ACK checks
// follow whether DEBUG_CMD_ACK_EN is defined for the build.
module tb_debug_cmd_parser;

`ifdef DEBUG_CMD_ACK_EN
  localparam logic ACK = 1'b1;
`else
  localparam logic ACK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] sel;
  logic [4:0] addr;
  logic       we;
  logic [7:0] wdata;
  logic [7:0] rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  debug_cmd_parser #(
    .CORES      (4),
    .LOG_CORES  (2),
    .DATA_WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel),
    .addr      (addr),
    .we        (we),
    .wdata     (wdata),
    .rdata     (rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns #1 after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic get_resp(input string tag, input logic [7:0] exp);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 1);
    check(tag, 32'(out_data), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    rdata     = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sel",       32'(sel), 0);
    check("rst_addr",      32'(addr), 0);
    check("rst_we",        32'(we), 0);
    check("rst_wdata",     32'(wdata), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data",  32'(out_data), 0);
    check("rst_in_ready",  32'(in_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 1);

    // SELECT 1, WRITE addr 0x0C data 0xAA
    send(8'h01);
    @(negedge clk);
    check("sel_1", 32'(sel), 1);
    if (ACK) get_resp("sel_ack", 8'h5A);
    send(8'h8C);
    @(negedge clk);
    check("waddr", 32'(addr), 32'h0C);
    check("we_early", 32'(we), 0);
    send(8'hAA);
    @(negedge clk);
    check("we_pulse", 32'(we), 1);
    check("wdata", 32'(wdata), 32'hAA);
    check("waddr_hold", 32'(addr), 32'h0C);
    @(negedge clk);
    check("we_off", 32'(we), 0);
    check("wr_ack_valid", 32'(out_valid), 32'(ACK));
    if (ACK) check("wr_ack", 32'(out_data), 32'h5A);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("wr_idle_ready", 32'(in_ready), 1);
    check("wdata_hold", 32'(wdata), 32'hAA);

    // READ addr 0x10 with backpressure
    rdata     = 8'hE1;
    out_ready = 1'b0;
    send(8'h50);
    @(negedge clk);
    check("raddr", 32'(addr), 32'h10);
    check("rd_not_yet", 32'(out_valid), 0);
    @(negedge clk);
    check("rd_valid", 32'(out_valid), 1);
    check("rd_data", 32'(out_data), 32'hE1);
    rdata = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 1);
      check("bp_data", 32'(out_data), 32'hE1);
      check("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rd_done_valid", 32'(out_valid), 0);
    check("rd_done_ready", 32'(in_ready), 1);

    // Invalid SELECT 7
    send(8'h07);
    @(negedge clk);
    check("bad_sel_hold", 32'(sel), 1);
    check("bad_sel_valid", 32'(out_valid), 32'(ACK));
    check("bad_sel_ready", 32'(in_ready), 32'(!ACK));
    if (ACK) check("bad_sel_err", 32'(out_data), 32'hEE);
    if (ACK) begin
      @(posedge clk);
      #1;
    end

    // ECHO, then ECHO again in the cycle right after the transfer
    send(8'hC0);
    @(negedge clk);
    check("echo_valid", 32'(out_valid), 1);
    check("echo_data", 32'(out_data), 32'hA5);
    in_valid = 1'b1;
    in_data  = 8'hC0;
    @(posedge clk);
    @(negedge clk);
    check("b2b_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("echo2_valid", 32'(out_valid), 1);
    check("echo2_data", 32'(out_data), 32'hA5);
    @(posedge clk);
    #1;

    // Reset during a write before its data byte
    send(8'h83);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_we", 32'(we), 0);
    check("mid_rst_addr", 32'(addr), 0);
    check("mid_rst_ready", 32'(in_ready), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("after_rst_we", 32'(we), 0);
      check("after_rst_ready", 32'(in_ready), 1);
    end
    rdata = 8'h3C;
    send(8'h50);
    @(negedge clk);
    check("rd2_addr", 32'(addr), 32'h10);
    get_resp("rd2", 8'h3C);
    check("final_we", 32'(we), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
